// File: rtl/frame_writeback_stream_pkg.sv
// Shared definitions for the frame write-back stage: controller states,
// BMP header constants and the row-stride / frame-size arithmetic.
package frame_writeback_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } fws_state_e;

  localparam logic [7:0] BMP_MAGIC_B    = 8'h42;
  localparam logic [7:0] BMP_MAGIC_M    = 8'h4D;
  localparam int         BMP_HDR_BYTES  = 54;
  localparam int         BMP_INFO_BYTES = 40;

  // Bytes per stored row, padded up to a multiple of 4 as BMP requires.
  function automatic int row_stride(input int width, input int channels);
    return ((width * channels + 3) / 4) * 4;
  endfunction

  function automatic int frame_bytes(input int width, input int height, input int channels);
    return height * row_stride(width, channels);
  endfunction

endpackage

// File: rtl/frame_writeback_stream_bmp_header_rom.sv
// 54-byte BMP file + info header, generated combinationally from the frame
// geometry. Only compiled in when BMP_HEADER_EN is defined; header mode
// supports 8-bit samples only and refuses to elaborate otherwise.
`ifdef BMP_HEADER_EN
module bmp_header_rom
  import frame_writeback_stream_pkg::*;
#(
  parameter int WIDTH    = 768,
  parameter int HEIGHT   = 512,
  parameter int CHANNELS = 3,
  parameter int DATA_W   = 8
) (
  input  logic [5:0] idx_i,
  output logic [7:0] byte_o
);

  localparam logic [31:0] IMG_SIZE  = 32'(frame_bytes(WIDTH, HEIGHT, CHANNELS));
  localparam logic [31:0] FILE_SIZE = 32'(BMP_HDR_BYTES) + IMG_SIZE;
  localparam logic [31:0] PIX_OFS   = 32'(BMP_HDR_BYTES);
  localparam logic [31:0] INFO_SZ   = 32'(BMP_INFO_BYTES);
  localparam logic [31:0] IMG_W     = 32'(WIDTH);
  localparam logic [31:0] IMG_H     = 32'(HEIGHT);
  localparam logic [31:0] PLANES    = 32'd1;
  localparam logic [31:0] BPP       = 32'(CHANNELS * DATA_W);

  if (DATA_W != 8) begin : g_bad_data_w
    $error("bmp_header_rom: BMP header mode requires DATA_W == 8");
  end

  function automatic logic [7:0] le_byte(input logic [31:0] v, input logic [1:0] k);
    return v[8*k +: 8];
  endfunction

  logic [5:0] ofs;
  assign ofs = idx_i - 6'd2;

  // Every 4-byte field starts at an index congruent to 2 mod 4, so the byte
  // lane within a field is simply (idx-2) mod 4.
  always_comb begin
    byte_o = '0;
    case (idx_i) inside
      6'd0:         byte_o = BMP_MAGIC_B;
      6'd1:         byte_o = BMP_MAGIC_M;
      [6'd2:6'd5]:   byte_o = le_byte(FILE_SIZE, ofs[1:0]);
      [6'd10:6'd13]: byte_o = le_byte(PIX_OFS, ofs[1:0]);
      [6'd14:6'd17]: byte_o = le_byte(INFO_SZ, ofs[1:0]);
      [6'd18:6'd21]: byte_o = le_byte(IMG_W, ofs[1:0]);
      [6'd22:6'd25]: byte_o = le_byte(IMG_H, ofs[1:0]);
      [6'd26:6'd27]: byte_o = le_byte(PLANES, ofs[1:0]);
      [6'd28:6'd29]: byte_o = le_byte(BPP, {1'b0, idx_i[0]});
      [6'd34:6'd37]: byte_o = le_byte(IMG_SIZE, ofs[1:0]);
      default:       byte_o = '0;
    endcase
  end

endmodule
`endif

// File: rtl/frame_writeback_stream.sv
// Frame write-back stage: captures a valid/ready pixel stream into on-chip
// memory bottom-up, then drains it as a BMP-ordered byte stream with 4-byte
// row padding. Define BMP_HEADER_EN to prefix the drain with a 54-byte BMP
// header. HRESETn is an active-high synchronous reset.
module frame_writeback_stream
  import frame_writeback_stream_pkg::*;
#(
  parameter int WIDTH      = 768,
  parameter int HEIGHT     = 512,
  parameter int CHANNELS   = 3,
  parameter int DATA_W     = 8,
  parameter int IDX_W      = 10,
  parameter int AUTO_DRAIN = 1
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sof,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  input  logic                       drain_req,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  output logic                       frame_done,
  output logic                       busy,
  output logic                       err_sof,
  output logic [IDX_W-1:0]           row_idx,
  output logic [IDX_W-1:0]           col_idx
);

  localparam int ROW_BYTES   = WIDTH * CHANNELS;
  localparam int ROW_STRIDE  = row_stride(WIDTH, CHANNELS);
  localparam int FRAME_BYTES = frame_bytes(WIDTH, HEIGHT, CHANNELS);
`ifdef BMP_HEADER_EN
  localparam int HDR_BYTES   = BMP_HDR_BYTES;
`else
  localparam int HDR_BYTES   = 0;
`endif
  localparam int TOTAL  = FRAME_BYTES + HDR_BYTES;
  localparam int CNT_W  = $clog2(TOTAL + 1);
  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CB_W   = $clog2(ROW_STRIDE + 1);
  localparam int CH_W   = $clog2(CHANNELS + 1);
  localparam int PIX_W  = CHANNELS * DATA_W;

  fws_state_e        state_q, state_d;
  logic [PIX_W-1:0]  mem_q [NPIX];
  logic [IDX_W-1:0]  row_q, col_q;
  logic              frame_done_q, err_sof_q;
  logic [CNT_W-1:0]  out_cnt_q;
  logic [IDX_W-1:0]  d_row_q, d_pix_q;
  logic [CB_W-1:0]   d_cb_q;
  logic [CH_W-1:0]   d_ch_q;
  logic              out_valid_q, out_last_q;
  logic [DATA_W-1:0] out_data_q;

  logic              accept, wr_en, wr_last, issue, last_taken, pad, in_hdr;
  logic [IDX_W-1:0]  wr_row, wr_col;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [PIX_W-1:0]  rd_word;
  logic [DATA_W-1:0] pix_byte, next_byte;

  // Memory holds whole pixels; the image row is flipped so memory row 0 is
  // the bottom image row, matching BMP's bottom-up order on drain.
  assign in_ready = (state_q == IDLE) || (state_q == FILL);
  assign accept   = in_valid && in_ready;
  assign wr_en    = accept && (in_sof || (state_q == FILL));
  assign wr_row   = in_sof ? '0 : row_q;
  assign wr_col   = in_sof ? '0 : col_q;
  assign wr_last  = (wr_row == IDX_W'(HEIGHT - 1)) && (wr_col == IDX_W'(WIDTH - 1));
  assign wr_addr  = ADDR_W'((HEIGHT - 1 - int'(wr_row)) * WIDTH + int'(wr_col));

  assign rd_addr    = ADDR_W'(int'(d_row_q) * WIDTH + int'(d_pix_q));
  assign rd_word    = mem_q[rd_addr];
  assign pad        = int'(d_cb_q) >= ROW_BYTES;
  assign pix_byte   = pad ? '0 : rd_word[int'(d_ch_q)*DATA_W +: DATA_W];
  assign issue      = (state_q == DRAIN) && (out_cnt_q != CNT_W'(TOTAL)) &&
                      (!out_valid_q || out_ready);
  assign last_taken = out_valid_q && out_ready && out_last_q;

`ifdef BMP_HEADER_EN
  logic [7:0] hdr_byte;

  bmp_header_rom #(
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .CHANNELS (CHANNELS),
    .DATA_W   (DATA_W)
  ) u_hdr (
    .idx_i  (out_cnt_q[5:0]),
    .byte_o (hdr_byte)
  );

  assign in_hdr    = out_cnt_q < CNT_W'(HDR_BYTES);
  assign next_byte = in_hdr ? DATA_W'(hdr_byte) : pix_byte;
`else
  assign in_hdr    = 1'b0;
  assign next_byte = pix_byte;
`endif

  // Controller state register.
  always_ff @(posedge HCLK) begin
    if (HRESETn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state: capture, wait for drain, stream out, back to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FILL: if (wr_en) state_d = wr_last ? FULL : FILL;
      FULL:       if ((AUTO_DRAIN != 0) || drain_req) state_d = DRAIN;
      DRAIN:      if (last_taken) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Write position, completion pulse and sticky sof protocol error.
  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      row_q        <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
      err_sof_q    <= 1'b0;
    end else begin
      frame_done_q <= wr_en && wr_last;
      if (accept && in_sof && (state_q == FILL) && ((row_q != '0) || (col_q != '0)))
        err_sof_q <= 1'b1;
      if (wr_en) begin
        if (wr_last) begin
          row_q <= '0;
          col_q <= '0;
        end else if (wr_col == IDX_W'(WIDTH - 1)) begin
          row_q <= wr_row + 1'b1;
          col_q <= '0;
        end else begin
          row_q <= wr_row;
          col_q <= wr_col + 1'b1;
        end
      end
    end
  end

  // Frame memory write; contents survive reset.
  always_ff @(posedge HCLK) begin
    if (wr_en) mem_q[wr_addr] <= in_data;
  end

  // Drain: registered output byte with row/pixel/channel walk and padding.
  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      d_row_q     <= '0;
      d_pix_q     <= '0;
      d_cb_q      <= '0;
      d_ch_q      <= '0;
    end else if (last_taken) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_cnt_q   <= '0;
      d_row_q     <= '0;
      d_pix_q     <= '0;
      d_cb_q      <= '0;
      d_ch_q      <= '0;
    end else if (issue) begin
      out_valid_q <= 1'b1;
      out_data_q  <= next_byte;
      out_last_q  <= (out_cnt_q == CNT_W'(TOTAL - 1));
      out_cnt_q   <= out_cnt_q + 1'b1;
      if (!in_hdr) begin
        if (int'(d_cb_q) == ROW_STRIDE - 1) begin
          d_cb_q  <= '0;
          d_pix_q <= '0;
          d_ch_q  <= '0;
          d_row_q <= d_row_q + 1'b1;
        end else begin
          d_cb_q <= d_cb_q + 1'b1;
          if (!pad) begin
            if (int'(d_ch_q) == CHANNELS - 1) begin
              d_ch_q  <= '0;
              d_pix_q <= d_pix_q + 1'b1;
            end else begin
              d_ch_q <= d_ch_q + 1'b1;
            end
          end
        end
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);
  assign err_sof    = err_sof_q;
  assign row_idx    = row_q;
  assign col_idx    = col_q;

endmodule
